// File: rtl/full_adder_seq_pkg.sv
// rtl/full_adder_seq_pkg.sv - shared constants and carry helper for the registered ripple adder
package full_adder_seq_pkg;

  localparam int unsigned FAS_DEFAULT_WIDTH = 1;

  // Merges the two half-adder generate terms into the slice carry-out.
  function automatic logic carry_merge(input logic i_g1, input logic i_g2);
    return i_g1 | i_g2;
  endfunction

endpackage

// File: rtl/full_adder_seq_bit.sv
// rtl/full_adder_seq_bit.sv - half adder cell and the one-bit full adder slice built from two of them

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder_bit
  import full_adder_seq_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  logic w_p;
  logic w_g1;
  logic w_g2;

  half_adder u_ha_ab (
    .x (i_a),
    .y (i_b),
    .s (w_p),
    .c (w_g1)
  );

  half_adder u_ha_pc (
    .x (w_p),
    .y (i_cin),
    .s (o_s),
    .c (w_g2)
  );

  assign o_cout = carry_merge(w_g1, w_g2);
endmodule

// File: rtl/full_adder_seq.sv
// rtl/full_adder_seq.sv - WIDTH-bit ripple-carry adder with registered sum, carry and valid
module full_adder_seq
  import full_adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = FAS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out
);
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    full_adder_bit u_fa (
      .i_a    (a[i]),
      .i_b    (b[i]),
      .i_cin  (w_carry[i]),
      .o_s    (w_sum[i]),
      .o_cout (w_carry[i+1])
    );
  end

  // Data registers load only on a valid sample, so idle-cycle input garbage never reaches them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry[WIDTH];
      end
    end
  end

  assign out_valid = r_valid;
  assign s_out     = r_sum;
  assign c_out     = r_carry;
endmodule

// File: tb/tb_full_adder_seq.sv
// tb/tb_full_adder_seq.sv - self-checking bench for full_adder_seq at WIDTH 1, 4 and 8
module tb_full_adder_seq;

  logic clk;
  logic rst;

  logic       v1_in, v1_a, v1_b, v1_c, v1_ov, v1_s, v1_co;
  logic       v4_in, v4_c, v4_ov, v4_co;
  logic [3:0] v4_a, v4_b, v4_s;
  logic       v8_in, v8_c, v8_ov, v8_co;
  logic [7:0] v8_a, v8_b, v8_s;

  int checks = 0;
  int errors = 0;

  full_adder_seq #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1_in), .a(v1_a), .b(v1_b), .c_in(v1_c),
    .out_valid(v1_ov), .s_out(v1_s), .c_out(v1_co)
  );

  full_adder_seq #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4_in), .a(v4_a), .b(v4_b), .c_in(v4_c),
    .out_valid(v4_ov), .s_out(v4_s), .c_out(v4_co)
  );

  full_adder_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8_in), .a(v8_a), .b(v8_b), .c_in(v8_c),
    .out_valid(v8_ov), .s_out(v8_s), .c_out(v8_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic a;
    logic b;
    logic c;
    logic s;
    logic co;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec8_t;

  vec1_t tbl1[8];
  vec8_t tbl8[3];

  logic [8:0] m_sum;
  logic [7:0] m_s;
  logic       m_co;
  logic       m_v;
  logic       rv;
  logic [7:0] ra, rb;
  logic       rc;

  initial begin
    tbl1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl8[0] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl8[1] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl8[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};

    rst = 1'b1;
    v1_in = 0; v1_a = 0; v1_b = 0; v1_c = 0;
    v4_in = 0; v4_a = 0; v4_b = 0; v4_c = 0;
    v8_in = 0; v8_a = 0; v8_b = 0; v8_c = 0;
    step();
    step();
    chk("reset_ov_w1", {63'd0, v1_ov}, 64'd0);
    chk("reset_s_w8", {56'd0, v8_s}, 64'd0);
    chk("reset_co_w8", {63'd0, v8_co}, 64'd0);
    rst = 1'b0;
    step();

    // WIDTH=1 exhaustive table
    for (int i = 0; i < 8; i++) begin
      v1_in = 1'b1; v1_a = tbl1[i].a; v1_b = tbl1[i].b; v1_c = tbl1[i].c;
      step();
      chk($sformatf("w1_ov_%0d", i), {63'd0, v1_ov}, 64'd1);
      chk($sformatf("w1_s_%0d", i), {63'd0, v1_s}, {63'd0, tbl1[i].s});
      chk($sformatf("w1_co_%0d", i), {63'd0, v1_co}, {63'd0, tbl1[i].co});
    end

    // Hold after (1,1)
    v1_in = 1'b0; v1_a = 0; v1_b = 0; v1_c = 0;
    step();
    chk("hold_ov", {63'd0, v1_ov}, 64'd0);
    chk("hold_s", {63'd0, v1_s}, 64'd1);
    chk("hold_co", {63'd0, v1_co}, 64'd1);
    step();
    chk("hold2_s", {63'd0, v1_s}, 64'd1);

    // WIDTH=4 boundaries
    v4_in = 1'b1; v4_a = 4'hF; v4_b = 4'h1; v4_c = 1'b0;
    step();
    chk("w4_f1_ov", {63'd0, v4_ov}, 64'd1);
    chk("w4_f1_s", {60'd0, v4_s}, 64'h0);
    chk("w4_f1_co", {63'd0, v4_co}, 64'd1);
    v4_a = 4'hF; v4_b = 4'hF; v4_c = 1'b1;
    step();
    chk("w4_ff1_s", {60'd0, v4_s}, 64'hF);
    chk("w4_ff1_co", {63'd0, v4_co}, 64'd1);
    v4_in = 1'b0;
    step();
    chk("w4_idle_ov", {63'd0, v4_ov}, 64'd0);

    // WIDTH=8 back-to-back
    for (int i = 0; i < 3; i++) begin
      v8_in = 1'b1; v8_a = tbl8[i].a; v8_b = tbl8[i].b; v8_c = tbl8[i].c;
      step();
      chk($sformatf("b2b_ov_%0d", i), {63'd0, v8_ov}, 64'd1);
      chk($sformatf("b2b_s_%0d", i), {56'd0, v8_s}, {56'd0, tbl8[i].s});
      chk($sformatf("b2b_co_%0d", i), {63'd0, v8_co}, {63'd0, tbl8[i].co});
    end
    v8_in = 1'b0; v8_a = 'x; v8_b = 'x; v8_c = 1'bx;
    step();
    chk("b2b_end_ov", {63'd0, v8_ov}, 64'd0);
    chk("xhold_s", {56'd0, v8_s}, 64'h00);
    chk("xhold_co", {63'd0, v8_co}, 64'd1);

    // Reset mid-stream between edges, with a result in flight
    v8_in = 1'b1; v8_a = 8'h55; v8_b = 8'h22; v8_c = 1'b1;
    step();
    chk("pre_rst_s", {56'd0, v8_s}, 64'h78);
    v8_a = 8'hF0; v8_b = 8'h0F; v8_c = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ov", {63'd0, v8_ov}, 64'd0);
    chk("rst_async_s", {56'd0, v8_s}, 64'd0);
    chk("rst_async_co", {63'd0, v8_co}, 64'd0);
    step();
    step();
    chk("rst_held_ov", {63'd0, v8_ov}, 64'd0);
    chk("rst_held_s", {56'd0, v8_s}, 64'd0);
    #4 rst = 1'b0;
    v8_in = 1'b0;
    step();
    chk("post_rst_ov", {63'd0, v8_ov}, 64'd0);
    chk("post_rst_s", {56'd0, v8_s}, 64'd0);
    v8_in = 1'b1; v8_a = 8'h01; v8_b = 8'h02; v8_c = 1'b0;
    step();
    chk("first_after_rst_ov", {63'd0, v8_ov}, 64'd1);
    chk("first_after_rst_s", {56'd0, v8_s}, 64'h03);

    // Randomized WIDTH=8 against an arithmetic model
    m_s = 8'h03; m_co = 1'b0; m_v = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      ra = 8'($urandom());
      rb = 8'($urandom());
      rc = 1'($urandom());
      v8_in = rv; v8_a = ra; v8_b = rb; v8_c = rc;
      step();
      if (rv) begin
        m_sum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
        m_s = m_sum[7:0];
        m_co = m_sum[8];
      end
      m_v = rv;
      chk($sformatf("rnd_ov_%0d", i), {63'd0, v8_ov}, {63'd0, m_v});
      chk($sformatf("rnd_s_%0d", i), {56'd0, v8_s}, {56'd0, m_s});
      chk($sformatf("rnd_co_%0d", i), {63'd0, v8_co}, {63'd0, m_co});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
